// File: rtl/controle_valvula_servo.sv
// Servo actuator stage for the water-level valve: ramps a 50 Hz hobby-servo PWM
// through 8 positions on open/close commands and reports valve status.
module controle_valvula_servo #(
    parameter int PERIODO_PWM        = 1_000_000,
    parameter int LARGURA_FECHADA    = 50_000,
    parameter int DELTA_LARGURA      = 7_000,
    parameter int PERIODOS_POR_PASSO = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       abre,
    input  logic       fecha,
    output logic       pwm,
    output logic       valvula_aberta,
    output logic       valvula_fechada,
    output logic       movendo,
    output logic [2:0] db_posicao,
    output logic [3:0] db_estado
);

    localparam int LW = 21;
    localparam int SW = $clog2(PERIODOS_POR_PASSO + 1);
    localparam logic [LW-1:0] FIM_PERIODO  = LW'(PERIODO_PWM - 1);
    localparam logic [SW-1:0] ULTIMO_PASSO = SW'(PERIODOS_POR_PASSO - 1);

    typedef enum logic [3:0] {
        FECHADA  = 4'd0,
        ABRINDO  = 4'd1,
        ABERTA   = 4'd2,
        FECHANDO = 4'd3
    } estado_t;

    estado_t        estado_q, estado_d;
    logic [2:0]     posicao_q, posicao_d;
    logic [LW-1:0]  cnt_pwm_q, cnt_pwm_d;
    logic [SW-1:0]  cnt_passo_q, cnt_passo_d;
    logic [LW-1:0]  largura_q, largura_d;
    logic           pwm_q, pwm_d;
    logic           fim_periodo_s;
    logic           passo_s;
    logic [LW-1:0]  largura_alvo_s;

    // PWM timebase; the width is taken at cnt_pwm==0 so a running pulse is never cut short
    always_comb begin
        fim_periodo_s  = (cnt_pwm_q == FIM_PERIODO);
        largura_alvo_s = LW'(LARGURA_FECHADA) + (LW'(posicao_q) * LW'(DELTA_LARGURA));
        if (fim_periodo_s) begin
            cnt_pwm_d = '0;
        end else begin
            cnt_pwm_d = cnt_pwm_q + LW'(1);
        end
        if (cnt_pwm_q == '0) begin
            largura_d = largura_alvo_s;
        end else begin
            largura_d = largura_q;
        end
        pwm_d = (cnt_pwm_q < largura_d);
    end

    // Valve FSM: fecha always wins, position moves one step every PERIODOS_POR_PASSO period ends
    always_comb begin
        estado_d    = estado_q;
        posicao_d   = posicao_q;
        cnt_passo_d = cnt_passo_q;
        passo_s     = fim_periodo_s && (cnt_passo_q == ULTIMO_PASSO);
        case (estado_q)
            FECHADA: begin
                if (abre && !fecha) begin
                    estado_d    = ABRINDO;
                    cnt_passo_d = '0;
                end else begin
                    estado_d = FECHADA;
                end
            end
            ABRINDO: begin
                if (fecha) begin
                    estado_d    = FECHANDO;
                    cnt_passo_d = '0;
                end else if (posicao_q == 3'd7) begin
                    estado_d = ABERTA;
                end else if (passo_s) begin
                    posicao_d   = posicao_q + 3'd1;
                    cnt_passo_d = '0;
                    if (posicao_q == 3'd6) begin
                        estado_d = ABERTA;
                    end else begin
                        estado_d = ABRINDO;
                    end
                end else if (fim_periodo_s) begin
                    cnt_passo_d = cnt_passo_q + SW'(1);
                end else begin
                    estado_d = ABRINDO;
                end
            end
            ABERTA: begin
                if (fecha) begin
                    estado_d    = FECHANDO;
                    cnt_passo_d = '0;
                end else begin
                    estado_d = ABERTA;
                end
            end
            FECHANDO: begin
                if (abre && !fecha) begin
                    estado_d    = ABRINDO;
                    cnt_passo_d = '0;
                end else if (posicao_q == 3'd0) begin
                    // reversal before the first step: already closed
                    estado_d = FECHADA;
                end else if (passo_s) begin
                    posicao_d   = posicao_q - 3'd1;
                    cnt_passo_d = '0;
                    if (posicao_q == 3'd1) begin
                        estado_d = FECHADA;
                    end else begin
                        estado_d = FECHANDO;
                    end
                end else if (fim_periodo_s) begin
                    cnt_passo_d = cnt_passo_q + SW'(1);
                end else begin
                    estado_d = FECHANDO;
                end
            end
            default: begin
                estado_d    = FECHADA;
                cnt_passo_d = '0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= FECHADA;
            posicao_q   <= 3'd0;
            cnt_pwm_q   <= '0;
            cnt_passo_q <= '0;
            largura_q   <= LW'(LARGURA_FECHADA);
            pwm_q       <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            posicao_q   <= posicao_d;
            cnt_pwm_q   <= cnt_pwm_d;
            cnt_passo_q <= cnt_passo_d;
            largura_q   <= largura_d;
            pwm_q       <= pwm_d;
        end
    end

    assign pwm             = pwm_q;
    assign valvula_aberta  = (estado_q == ABERTA);
    assign valvula_fechada = (estado_q == FECHADA);
    assign movendo         = (estado_q == ABRINDO) || (estado_q == FECHANDO);
    assign db_posicao      = posicao_q;
    assign db_estado       = estado_q;

endmodule

// File: tb/tb_controle_valvula_servo.sv
// Scoreboard bench: stimulus queues time-stamped expectations, a negedge monitor checks them.
module tb_controle_valvula_servo;

    logic       clock = 1'b0;
    logic       reset, abre, fecha;
    logic       pwm, valvula_aberta, valvula_fechada, movendo;
    logic [2:0] db_posicao;
    logic [3:0] db_estado;

    controle_valvula_servo #(
        .PERIODO_PWM(100), .LARGURA_FECHADA(10), .DELTA_LARGURA(5), .PERIODOS_POR_PASSO(2)
    ) dut (
        .clock(clock), .reset(reset), .abre(abre), .fecha(fecha),
        .pwm(pwm), .valvula_aberta(valvula_aberta), .valvula_fechada(valvula_fechada),
        .movendo(movendo), .db_posicao(db_posicao), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    localparam int S_PWM = 0, S_ABER = 1, S_FECH = 2, S_MOV = 3, S_POS = 4, S_EST = 5, S_WID = 6;

    typedef struct { int at; int sel; int exp; } chk_t;
    chk_t q[$];
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int run_len = 0;
    int last_w = 0;
    int B;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic string nome(input int sel);
        case (sel)
            S_PWM:   return "pwm";
            S_ABER:  return "valvula_aberta";
            S_FECH:  return "valvula_fechada";
            S_MOV:   return "movendo";
            S_POS:   return "db_posicao";
            S_EST:   return "db_estado";
            default: return "pulse_width";
        endcase
    endfunction

    function automatic int atual(input int sel);
        case (sel)
            S_PWM:   return int'(pwm);
            S_ABER:  return int'(valvula_aberta);
            S_FECH:  return int'(valvula_fechada);
            S_MOV:   return int'(movendo);
            S_POS:   return int'(db_posicao);
            S_EST:   return int'(db_estado);
            default: return last_w;
        endcase
    endfunction

    task automatic expect_at(input int at, input int sel, input int exp);
        chk_t c;
        c.at = at; c.sel = sel; c.exp = exp;
        q.push_back(c);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    // Monitor: track pwm pulse widths, then compare every expectation due this cycle
    always @(negedge clock) begin
        if (pwm === 1'b1) begin
            run_len = run_len + 1;
        end else if (run_len != 0) begin
            last_w  = run_len;
            run_len = 0;
        end
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].at == cyc) begin
                n_cmp = n_cmp + 1;
                if (atual(q[i].sel) !== q[i].exp) begin
                    n_bad = n_bad + 1;
                    $display("FAIL %s at cycle %0d: got %0d, expected %0d",
                             nome(q[i].sel), cyc, atual(q[i].sel), q[i].exp);
                end
                q.delete(i);
            end
        end
    end

    initial begin
        reset = 1'b1; abre = 1'b0; fecha = 1'b0;
        @(negedge clock); @(negedge clock);
        expect_at(cyc + 1, S_PWM, 0);  expect_at(cyc + 1, S_FECH, 1);
        expect_at(cyc + 1, S_ABER, 0); expect_at(cyc + 1, S_MOV, 0);
        expect_at(cyc + 1, S_POS, 0);  expect_at(cyc + 1, S_EST, 0);
        @(negedge clock);
        reset = 1'b0;
        B = cyc;

        // idle: closed width 10 every 100 cycles
        expect_at(B + 1, S_PWM, 1);   expect_at(B + 10, S_PWM, 1);
        expect_at(B + 11, S_PWM, 0);  expect_at(B + 101, S_PWM, 1);
        expect_at(B + 115, S_WID, 10); expect_at(B + 215, S_WID, 10);
        expect_at(B + 300, S_FECH, 1); expect_at(B + 300, S_EST, 0);
        expect_at(B + 300, S_MOV, 0);

        // full open from a single-cycle pulse
        wait_until(B + 305);
        abre = 1'b1;
        expect_at(B + 306, S_MOV, 1); expect_at(B + 306, S_EST, 1); expect_at(B + 306, S_FECH, 0);
        @(negedge clock); abre = 1'b0;
        expect_at(B + 499, S_POS, 0);   expect_at(B + 500, S_POS, 1);
        expect_at(B + 520, S_WID, 15);
        expect_at(B + 1699, S_POS, 6);  expect_at(B + 1699, S_ABER, 0);
        expect_at(B + 1700, S_POS, 7);  expect_at(B + 1700, S_ABER, 1);
        expect_at(B + 1700, S_MOV, 0);
        expect_at(B + 1745, S_PWM, 1);  expect_at(B + 1746, S_PWM, 0);
        expect_at(B + 1750, S_WID, 45);

        // close from open
        wait_until(B + 1805);
        fecha = 1'b1;
        expect_at(B + 1806, S_EST, 3); expect_at(B + 1806, S_ABER, 0); expect_at(B + 1806, S_MOV, 1);
        @(negedge clock); fecha = 1'b0;
        expect_at(B + 2000, S_POS, 6);  expect_at(B + 2045, S_WID, 40);
        expect_at(B + 3199, S_POS, 1);  expect_at(B + 3199, S_EST, 3);
        expect_at(B + 3200, S_POS, 0);  expect_at(B + 3200, S_FECH, 1);
        expect_at(B + 3200, S_EST, 0);  expect_at(B + 3250, S_WID, 10);

        // reversal at position 3
        wait_until(B + 3305);
        abre = 1'b1;
        expect_at(B + 3306, S_EST, 1);
        @(negedge clock); abre = 1'b0;
        expect_at(B + 3900, S_POS, 3); expect_at(B + 3930, S_WID, 25);
        wait_until(B + 3905);
        fecha = 1'b1;
        expect_at(B + 3906, S_EST, 3); expect_at(B + 3906, S_POS, 3);
        @(negedge clock); fecha = 1'b0;
        expect_at(B + 4099, S_POS, 3);  expect_at(B + 4100, S_POS, 2);
        expect_at(B + 4130, S_WID, 20); expect_at(B + 4300, S_POS, 1);
        expect_at(B + 4330, S_WID, 15); expect_at(B + 4500, S_POS, 0);
        expect_at(B + 4500, S_EST, 0);  expect_at(B + 4530, S_WID, 10);

        // conflict: held in FECHADA stays closed, in ABRINDO fecha wins
        wait_until(B + 4605);
        abre = 1'b1; fecha = 1'b1;
        expect_at(B + 4606, S_EST, 0); expect_at(B + 4620, S_EST, 0); expect_at(B + 4620, S_FECH, 1);
        wait_until(B + 4625);
        abre = 1'b0; fecha = 1'b0;
        wait_until(B + 4630);
        abre = 1'b1;
        expect_at(B + 4631, S_EST, 1);
        @(negedge clock); fecha = 1'b1;
        expect_at(B + 4632, S_EST, 3); expect_at(B + 4632, S_POS, 0);
        wait_until(B + 4640);
        abre = 1'b0; fecha = 1'b0;

        // reset mid-travel at position 4
        wait_until(B + 4705);
        abre = 1'b1;
        expect_at(B + 4706, S_EST, 1);
        @(negedge clock); abre = 1'b0;
        expect_at(B + 5500, S_POS, 4); expect_at(B + 5510, S_PWM, 1);
        wait_until(B + 5510);
        reset = 1'b1;
        expect_at(B + 5511, S_EST, 0); expect_at(B + 5511, S_POS, 0);
        expect_at(B + 5511, S_PWM, 0); expect_at(B + 5511, S_MOV, 0);
        expect_at(B + 5511, S_FECH, 1);
        @(negedge clock); reset = 1'b0;
        expect_at(B + 5512, S_PWM, 1); expect_at(B + 5521, S_PWM, 1);
        expect_at(B + 5522, S_PWM, 0); expect_at(B + 5530, S_WID, 10);

        wait_until(B + 5540);
        if (q.size() != 0) begin
            $display("FAIL pending_checks: got %0d unchecked, expected 0", q.size());
            n_bad = n_bad + q.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
